pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS32 core. Merges stall requests from the
//  id/ex/mem stages into one per-stage stall vector for pc, if_id, id_ex, ex_mem
//  and mem_wb. Sequences exception flushes (flush pulse + redirect PC). Runs a
//  stall watchdog and a stall-cycle performance counter.
// PARAMETERS
//  STALL_TIMEOUT  1024  consecutive stalled cycles that set stall_timeout
//  WDOG_W         16    watchdog counter width (must hold STALL_TIMEOUT)
//  PERF_W         32    stall_cycles counter width
// PORTS
//  clk              in   1       core clock, rising edge
//  rst              in   1       asynchronous reset, active-high
//  stallreq_id      in   1       id needs a stall (load-use hazard)
//  stallreq_ex      in   1       ex needs a stall (multi-cycle mul/div)
//  stallreq_mem     in   1       mem needs a stall (bus wait)
//  excp_req         in   1       level: exception pending at mem stage
//  excp_vector      in   32      handler address, valid with excp_req
//  timeout_clr      in   1       clears sticky stall_timeout
//  stall            out  6       [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1=hold
//  flush            out  1       clear all pipeline registers to NOP values
//  new_pc           out  32      redirect target, valid while flush=1
//  excp_ack         out  1       one-cycle accept pulse, coincides with flush
//  stall_timeout    out  1       sticky watchdog flag
//  stall_cycles     out  PERF_W  total stalled cycles, wraps
// BEHAVIOUR
//  Reset, async: state=RUN, flush=0, new_pc=0, excp_ack=0, stall_timeout=0,
//   stall_cycles=0, watchdog=0. stall=0 during reset.
//  States RUN, FLUSH. State and registered outputs update on the rising edge of clk.
//  Stall vector is combinational from the requests, in RUN only. Highest stage wins:
//   stallreq_mem -> 6'b011111. Else stallreq_ex -> 6'b001111.
//   Else stallreq_id -> 6'b000111. Else 6'b000000.
//  In FLUSH, stall=0 regardless of requests.
//  RUN->FLUSH: at an edge in RUN with excp_req=1 and stallreq_mem=0.
//   Capture new_pc<=excp_vector.
//   In the next cycle: flush=1 and excp_ack=1 (both registered).
//  excp_req with stallreq_mem=1 is held off. It is accepted at the first edge where
//   stallreq_mem=0; stall stays 6'b011111 meanwhile. excp_req beats ex/id stalls.
//  FLUSH->RUN unconditionally after one cycle. flush and excp_ack drop to 0;
//   new_pc holds its value. excp_req seen in FLUSH is ignored; if it is still
//   high in RUN, it is accepted again (requester drops it on excp_ack).
//  Watchdog: in RUN with stall!=0, counter +1, saturating at STALL_TIMEOUT.
//   In any other cycle it clears to 0. On the edge where it reaches STALL_TIMEOUT,
//   stall_timeout<=1 (sticky).
//  timeout_clr=1: stall_timeout<=0 and watchdog<=0. If a new timeout coincides
//   with timeout_clr, clear wins.
//  stall_cycles: +1 at each edge where stall!=0, modulo 2^PERF_W. Never stops.
//  Reset mid-FLUSH aborts the flush: flush=0 at once, with no further pulse.
// TESTING
//  T1 reset: rst=1 with random inputs -> all outputs 0, stall=0, state RUN.
//  T2 priority: id=1,ex=1 -> stall=6'b001111; add mem=1 -> 6'b011111;
//     all 0 -> 6'b000000 in the same cycle.
//  T3 exception: excp_req=1, vector=32'hBFC00380, no stalls -> next cycle
//     flush=1, excp_ack=1, new_pc=32'hBFC00380 for exactly one cycle; stall=0.
//  T4 held exception: excp_req=1 with mem stall for 5 cycles -> no flush, stall=011111;
//     mem drops -> flush one cycle later, stall_cycles +5.
//  T5 watchdog: STALL_TIMEOUT=8, ex stall 8 cycles -> stall_timeout=1 after edge 8, stays 1
//     when the stall ends; timeout_clr pulse -> 0; 7-cycle stall -> stays 0.
//  T6 wrap/reset: PERF_W=4, 17 stalled cycles -> stall_cycles=1;
//     rst asserted during flush=1 -> flush=0 immediately.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS32 core: merges stage stall requests,
// sequences exception flushes, and runs a stall watchdog plus stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned WDOG_W        = 16,
    parameter int unsigned PERF_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              excp_req,
    input  logic [31:0]       excp_vector,
    input  logic              timeout_clr,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              excp_ack,
    output logic              stall_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(STALL_TIMEOUT);

    logic [0:0]        state;
    logic [WDOG_W-1:0] wdog;
    logic              stalled;
    logic              accept;

    // Highest requesting stage wins; nothing is held while flushing or in reset.
    always_comb begin
        stall = '0;
        if (!rst && state == RUN) begin
            if (stallreq_mem)
                stall = 6'b011111;
            else if (stallreq_ex)
                stall = 6'b001111;
            else if (stallreq_id)
                stall = 6'b000111;
        end
    end

    assign stalled = (stall != '0);
    assign accept  = (state == RUN) && excp_req && !stallreq_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            flush    <= 1'b0;
            excp_ack <= 1'b0;
            new_pc   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        state    <= FLUSH;
                        new_pc   <= excp_vector;
                        flush    <= 1'b1;
                        excp_ack <= 1'b1;
                    end else begin
                        flush    <= 1'b0;
                        excp_ack <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    flush    <= 1'b0;
                    excp_ack <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog          <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            stall_cycles <= stall_cycles + PERF_W'(stalled);
            // Clear takes priority over a timeout landing on the same edge.
            if (timeout_clr) begin
                wdog          <= '0;
                stall_timeout <= 1'b0;
            end else if (stalled) begin
                if (wdog != WDOG_MAX)
                    wdog <= wdog + 1'b1;
                if (wdog == WDOG_MAX - 1'b1)
                    stall_timeout <= 1'b1;
            end else begin
                wdog <= '0;
            end
        end
    end

endmodule
